// File: rtl/ap_div_pkg.sv
// Shared types and defaults for the approximate-arithmetic unsigned divider.
// Contents: FSM state enum, default WIDTH/TRUNC_BITS, error-result quotient.
package ap_div_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned TRUNC_BITS_DEF = 4;

  // Quotient reported for divide-by-zero and overflow results.
  localparam logic [WIDTH_DEF-1:0] QUOT_ERR = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ap_div_step.sv
// One radix-2 restoring division step (combinational).
// Ports:
//   part_rem   in  WIDTH  partial remainder, always < divisor
//   in_bit     in  1      next dividend bit, MSB first
//   divisor    in  WIDTH  divisor
//   next_rem_c out WIDTH  updated partial remainder
//   q_bit_c    out 1      quotient bit produced by this step
module ap_div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem_c,
  output logic             q_bit_c
);

  logic [WIDTH:0] trial;

  // Trial is WIDTH+1 bits wide, so the compare/subtract never truncates.
  always_comb begin
    trial      = {part_rem, in_bit};
    q_bit_c    = (trial >= {1'b0, divisor});
    next_rem_c = q_bit_c ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/ap_unsi_seq_div_8b.sv
// Iterative radix-2 restoring unsigned divider, 2*WIDTH / WIDTH -> WIDTH q, WIDTH r.
// One quotient bit per clock, valid/ready handshake on both sides.
// Optional macro AP_DIV_TRUNC_EN: compute only TRUNC_BITS quotient MSBs, force
// the remaining quotient LSBs and the remainder to 0.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid/in_ready, dividend[2W], divisor[W]     operand handshake
//   out_valid/out_ready, quotient[W], remainder[W]  result handshake
//   div_by_zero, overflow                           result flags (with out_valid)
module ap_unsi_seq_div_8b
  import ap_div_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned TRUNC_BITS = TRUNC_BITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

`ifdef AP_DIV_TRUNC_EN
  localparam bit TRUNC_EN = 1'b1;
`else
  localparam bit TRUNC_EN = 1'b0;
`endif

  localparam int unsigned ITERS = TRUNC_EN ? TRUNC_BITS : WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] QUOT_ERR_W = {WIDTH{QUOT_ERR[0]}};

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] low, low_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quot_d, rem_d, quot_shift;
  logic             in_ready_d, out_valid_d, dbz_d, ovf_d;
  logic [WIDTH-1:0] step_rem_c;
  logic             step_bit_c;

  // Remainder register doubles as the partial remainder during CALC.
  ap_div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem   (remainder),
    .in_bit     (low[WIDTH-1]),
    .divisor    (div_q),
    .next_rem_c (step_rem_c),
    .q_bit_c    (step_bit_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    low_d      = low;
    div_d      = div_q;
    quot_d     = quotient;
    rem_d      = remainder;
    dbz_d      = div_by_zero;
    ovf_d      = overflow;
    quot_shift = WIDTH'({quotient, step_bit_c});

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          dbz_d = 1'b0;
          ovf_d = 1'b0;
          cnt_d = '0;
          div_d = divisor;
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quot_d  = QUOT_ERR_W;
            rem_d   = dividend[WIDTH-1:0];
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            state_d = DONE;
            ovf_d   = 1'b1;
            quot_d  = QUOT_ERR_W;
            rem_d   = '0;
          end else begin
            state_d = CALC;
            quot_d  = '0;
            rem_d   = dividend[2*WIDTH-1:WIDTH];
            low_d   = dividend[WIDTH-1:0];
          end
        end
      end
      CALC: begin
        rem_d  = step_rem_c;
        low_d  = WIDTH'({low, 1'b0});
        cnt_d  = cnt + CNT_W'(1);
        quot_d = quot_shift;
        if (cnt == CNT_W'(ITERS - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          // Skipped iterations leave their quotient LSBs at zero.
          quot_d  = quot_shift << (WIDTH - ITERS);
          if (TRUNC_EN) rem_d = '0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      low         <= '0;
      div_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      low         <= low_d;
      div_q       <= div_d;
      quotient    <= quot_d;
      remainder   <= rem_d;
      div_by_zero <= dbz_d;
      overflow    <= ovf_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
    end
  end

endmodule

// File: doc/ap_unsi_seq_div_8b.md
Name: ap_unsi_seq_div_8b

Overview:
- Iterative radix-2 restoring unsigned divider. It is the inverse operation of the 8x8->16 unsigned multiplier datapath: it takes a 16-bit product-width dividend and an 8-bit divisor, and returns an 8-bit quotient and an 8-bit remainder.
- Used as the reference/inverse check engine and as the divide unit in the approximate-arithmetic family.
- Valid/ready handshake on both input and output; one quotient bit per clock.

Parameters:
- WIDTH, 8, divisor/quotient/remainder width; dividend is 2*WIDTH.
- TRUNC_BITS, 4, number of quotient MSBs computed when AP_DIV_TRUNC_EN is defined; legal range 1..WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  2*WIDTH  unsigned dividend.
- divisor  in  WIDTH  unsigned divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  WIDTH  unsigned quotient.
- remainder  out  WIDTH  unsigned remainder.
- div_by_zero  out  1  divisor was 0; qualified by out_valid.
- overflow  out  1  quotient does not fit in WIDTH bits; qualified by out_valid.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, state=IDLE, cnt=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch operands.
    - divisor==0 -> DONE with div_by_zero=1, quotient=all-ones, remainder=dividend[WIDTH-1:0].
    - else if dividend[2W-1:W] >= divisor -> DONE with overflow=1, quotient=all-ones, remainder=0.
    - else -> CALC with partial remainder R=dividend[2W-1:W], low shift register=dividend[W-1:0], cnt=0.
  - CALC: in_ready=0. Each cycle:
    - T={R, next dividend bit (MSB first)}, WIDTH+1 bits.
    - If T>=divisor: R=T-divisor and quotient bit=1; else R=T[W-1:0] and bit=0.
    - Quotient is shifted in LSB-side, MSB first.
    - cnt increments; after the iteration with cnt==WIDTH-1 -> DONE.
  - DONE: out_valid=1 and outputs stable. On out_ready -> IDLE; out_valid deasserts on the next edge. in_ready stays 0 in DONE, so a new operand is never accepted in the same cycle as the result handshake.
- Latency, counted from the accepting edge:
  - Normal: out_valid high after WIDTH+1 edges (9 for WIDTH=8).
  - Error cases: after 1 edge.
- Backpressure: with out_ready=0, DONE holds indefinitely; quotient, remainder and flags must not change.
- Flags are mutually exclusive; divide-by-zero takes priority over overflow.
- Flags are cleared when the next operand is accepted.
- in_valid while not in IDLE is ignored; the upstream holds it under valid/ready rules.
- rst asserted in any state, including mid-CALC: next edge returns to reset values and the partial result is discarded.
- Arithmetic is unsigned only. The comparison/subtract uses WIDTH+1 bits, so no intermediate truncation occurs.

Optional Feature:
- Macro AP_DIV_TRUNC_EN.
- Defined:
  - Approximate mode: only TRUNC_BITS CALC iterations run (the MSBs).
  - The remaining WIDTH-TRUNC_BITS quotient LSBs are forced to 0; remainder output is 0.
  - Normal latency is TRUNC_BITS+1 edges. Error paths are unchanged.
- Undefined: exact division as above; the TRUNC_BITS parameter has no effect.

Decomposition:
- Package ap_div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - default WIDTH/TRUNC_BITS localparams;
  - the all-ones quotient constant for error results.
- One combinational sub-module, ap_div_step: inputs R, incoming bit, divisor; outputs new R and quotient bit.
- The FSM, counter and registers stay in the top module.

Test Plan:
- Exact divide: dividend=1000, divisor=7, out_ready=1 -> quotient=142, remainder=6, flags 0, out_valid 9 edges after accept.
- Maximum legal operands: dividend=65025, divisor=255 -> quotient=255, remainder=0, overflow=0.
- Divide by zero: dividend=0x1234, divisor=0 -> div_by_zero=1, quotient=0xFF, remainder=0x34, out_valid 1 edge after accept.
- Overflow: dividend=0x0800, divisor=8 -> overflow=1, quotient=0xFF, remainder=0.
- Backpressure and reset:
  - Hold out_ready=0 for 20 cycles on 1000/7 -> outputs stable, in_ready=0.
  - Second run with rst pulsed mid-CALC -> in_ready=1, out_valid=0 next cycle.
  - Following 100/3 -> quotient=33, remainder=1.
- With AP_DIV_TRUNC_EN and TRUNC_BITS=4: 1000/7 -> quotient=0x80, remainder=0, out_valid 5 edges after accept.
